// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the RV32I core with integrated load-use hazard
//   detection. Decoded operands, immediate, PC, register indices and the ID
//   control bundle are registered and presented to EX one cycle later.
//   Bubbles (all-zero control, ex_valid=0) are inserted on control-flow
//   flushes and on load-use hazards; a downstream hold freezes the stage.
//
// Configuration macro:
//   ID_EX_PERF_CNT_EN - when defined, stall_cnt / flush_cnt are saturating
//                       performance counters; otherwise both are tied to 0.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   id_valid                ID holds a real instruction
//   id_pc/rs1_val/rs2_val/imm   XLEN-wide decoded datapath values
//   id_rs1/rs2/rd           register indices
//   id_funct                {funct7[5], funct3}
//   *_in                    decoder control bundle
//   flush_in                EX redirect, kills the ID instruction
//   hold_in                 downstream stall, freezes this stage
//   ex_*                    registered copies for EX
//   ex_valid                EX holds a real instruction
//   load_use_stall          combinational, upstream must hold
//   stall_cnt, flush_cnt    performance counters
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rs1_val,
  input  logic [XLEN-1:0]      id_rs2_val,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [3:0]           id_funct,
  input  logic                 mem_rd_in,
  input  logic                 mem_wr_in,
  input  logic                 reg_wr_in,
  input  logic                 mux_reg_wr_in,
  input  logic                 jump_in,
  input  logic                 branch_in,
  input  logic                 jalr_in,
  input  logic [1:0]           ula_op_in,
  input  logic [1:0]           alu_src1_in,
  input  logic [1:0]           alu_src2_in,
  input  logic                 flush_in,
  input  logic                 hold_in,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rs1_val,
  output logic [XLEN-1:0]      ex_rs2_val,
  output logic [XLEN-1:0]      ex_imm,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [3:0]           ex_funct,
  output logic                 ex_mem_rd,
  output logic                 ex_mem_wr,
  output logic                 ex_reg_wr,
  output logic                 ex_mux_reg_wr,
  output logic                 ex_jump,
  output logic                 ex_branch,
  output logic                 ex_jalr,
  output logic [1:0]           ex_ula_op,
  output logic [1:0]           ex_alu_src1,
  output logic [1:0]           ex_alu_src2,
  output logic                 ex_valid,
  output logic                 load_use_stall,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
);

  localparam logic [REG_IDX_W-1:0] REG_X0 = {REG_IDX_W{1'b0}};
  localparam logic [XLEN-1:0]      DATA_Z = {XLEN{1'b0}};

  // Registered state
  logic [XLEN-1:0]      pc_r, rs1_val_r, rs2_val_r, imm_r;
  logic [REG_IDX_W-1:0] rs1_r, rs2_r, rd_r;
  logic [3:0]           funct_r;
  logic                 mem_rd_r, mem_wr_r, reg_wr_r, mux_reg_wr_r;
  logic                 jump_r, branch_r, jalr_r, valid_r;
  logic [1:0]           ula_op_r, alu_src1_r, alu_src2_r;

  // Next-state values
  logic [XLEN-1:0]      pc_s, rs1_val_s, rs2_val_s, imm_s;
  logic [REG_IDX_W-1:0] rs1_s, rs2_s, rd_s;
  logic [3:0]           funct_s;
  logic                 mem_rd_s, mem_wr_s, reg_wr_s, mux_reg_wr_s;
  logic                 jump_s, branch_s, jalr_s, valid_s;
  logic [1:0]           ula_op_s, alu_src1_s, alu_src2_s;

  logic hit1_s, hit2_s, load_use_s, bubble_s, stall_evt_s, flush_evt_s;

  // Load-use hazard: a load in EX whose rd feeds an operand actually read by ID.
  // rs2 is also consumed by stores (data) and branches (compare), whatever
  // alu_src2 selects.
  always_comb begin
    hit1_s      = (alu_src1_in == 2'b00) && (id_rs1 == rd_r);
    hit2_s      = ((alu_src2_in == 2'b00) || mem_wr_in || branch_in) && (id_rs2 == rd_r);
    load_use_s  = valid_r && mem_rd_r && (rd_r != REG_X0) && id_valid && !flush_in
                  && (hit1_s || hit2_s);
    // A flush outranks hold; a load-use bubble only goes in when not held.
    bubble_s    = flush_in || (!hold_in && load_use_s);
    stall_evt_s = !flush_in && !hold_in && load_use_s;
    flush_evt_s = flush_in && id_valid;
  end

  assign load_use_stall = load_use_s;

  // Next-state selection: bubble, hold, or capture with control sanitisation.
  always_comb begin
    pc_s = pc_r;  rs1_val_s = rs1_val_r;  rs2_val_s = rs2_val_r;  imm_s = imm_r;
    rs1_s = rs1_r;  rs2_s = rs2_r;  rd_s = rd_r;  funct_s = funct_r;
    mem_rd_s = mem_rd_r;  mem_wr_s = mem_wr_r;  reg_wr_s = reg_wr_r;
    mux_reg_wr_s = mux_reg_wr_r;  jump_s = jump_r;  branch_s = branch_r;
    jalr_s = jalr_r;  ula_op_s = ula_op_r;  alu_src1_s = alu_src1_r;
    alu_src2_s = alu_src2_r;  valid_s = valid_r;
    if (bubble_s) begin
      pc_s = DATA_Z;  rs1_val_s = DATA_Z;  rs2_val_s = DATA_Z;  imm_s = DATA_Z;
      rs1_s = REG_X0;  rs2_s = REG_X0;  rd_s = REG_X0;  funct_s = 4'h0;
      mem_rd_s = 1'b0;  mem_wr_s = 1'b0;  reg_wr_s = 1'b0;  mux_reg_wr_s = 1'b0;
      jump_s = 1'b0;  branch_s = 1'b0;  jalr_s = 1'b0;
      ula_op_s = 2'b00;  alu_src1_s = 2'b00;  alu_src2_s = 2'b00;
      valid_s = 1'b0;
    end else if (hold_in) begin
      valid_s = valid_r;
    end else begin
      pc_s = id_pc;  rs1_val_s = id_rs1_val;  rs2_val_s = id_rs2_val;  imm_s = id_imm;
      rs1_s = id_rs1;  rs2_s = id_rs2;  rd_s = id_rd;  funct_s = id_funct;
      valid_s = id_valid;
      if (id_valid) begin
        // Branches and stores never write back; writes to x0 are dropped here
        // so forwarding logic never sees a false producer.
        reg_wr_s     = reg_wr_in && !branch_in && !mem_wr_in && (id_rd != REG_X0);
        mem_rd_s     = mem_rd_in && !mem_wr_in;
        mem_wr_s     = mem_wr_in;
        mux_reg_wr_s = mux_reg_wr_in;
        jump_s       = jump_in;
        branch_s     = branch_in;
        jalr_s       = jalr_in;
        ula_op_s     = ula_op_in;
        alu_src1_s   = alu_src1_in;
        alu_src2_s   = alu_src2_in;
      end else begin
        reg_wr_s = 1'b0;  mem_rd_s = 1'b0;  mem_wr_s = 1'b0;  mux_reg_wr_s = 1'b0;
        jump_s = 1'b0;  branch_s = 1'b0;  jalr_s = 1'b0;
        ula_op_s = 2'b00;  alu_src1_s = 2'b00;  alu_src2_s = 2'b00;
      end
    end
  end

  // Pipeline register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= DATA_Z;  rs1_val_r <= DATA_Z;  rs2_val_r <= DATA_Z;  imm_r <= DATA_Z;
      rs1_r <= REG_X0;  rs2_r <= REG_X0;  rd_r <= REG_X0;  funct_r <= 4'h0;
      mem_rd_r <= 1'b0;  mem_wr_r <= 1'b0;  reg_wr_r <= 1'b0;  mux_reg_wr_r <= 1'b0;
      jump_r <= 1'b0;  branch_r <= 1'b0;  jalr_r <= 1'b0;
      ula_op_r <= 2'b00;  alu_src1_r <= 2'b00;  alu_src2_r <= 2'b00;
      valid_r <= 1'b0;
    end else begin
      pc_r <= pc_s;  rs1_val_r <= rs1_val_s;  rs2_val_r <= rs2_val_s;  imm_r <= imm_s;
      rs1_r <= rs1_s;  rs2_r <= rs2_s;  rd_r <= rd_s;  funct_r <= funct_s;
      mem_rd_r <= mem_rd_s;  mem_wr_r <= mem_wr_s;  reg_wr_r <= reg_wr_s;
      mux_reg_wr_r <= mux_reg_wr_s;  jump_r <= jump_s;  branch_r <= branch_s;
      jalr_r <= jalr_s;  ula_op_r <= ula_op_s;  alu_src1_r <= alu_src1_s;
      alu_src2_r <= alu_src2_s;  valid_r <= valid_s;
    end
  end

  assign ex_pc = pc_r;  assign ex_rs1_val = rs1_val_r;  assign ex_rs2_val = rs2_val_r;
  assign ex_imm = imm_r;  assign ex_rs1 = rs1_r;  assign ex_rs2 = rs2_r;
  assign ex_rd = rd_r;  assign ex_funct = funct_r;  assign ex_mem_rd = mem_rd_r;
  assign ex_mem_wr = mem_wr_r;  assign ex_reg_wr = reg_wr_r;
  assign ex_mux_reg_wr = mux_reg_wr_r;  assign ex_jump = jump_r;
  assign ex_branch = branch_r;  assign ex_jalr = jalr_r;  assign ex_ula_op = ula_op_r;
  assign ex_alu_src1 = alu_src1_r;  assign ex_alu_src2 = alu_src2_r;
  assign ex_valid = valid_r;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_r, flush_cnt_r;

  // Saturating performance counters for load-use bubbles and real flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'h0000_0000;
      flush_cnt_r <= 32'h0000_0000;
    end else begin
      if (stall_evt_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_evt_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'h0000_0001;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  logic unused_evt_s;
  assign unused_evt_s = stall_evt_s ^ flush_evt_s;
  assign stall_cnt    = 32'h0000_0000;
  assign flush_cnt    = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed-vector bench for id_ex_stage. Inputs change 1 time unit after a
//   rising edge; registered outputs are checked 1 unit after the edge that
//   captured them, combinational load_use_stall right after driving inputs.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic        mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in, jump_in, branch_in, jalr_in;
  logic [1:0]  ula_op_in, alu_src1_in, alu_src2_in;
  logic        flush_in, hold_in;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic        ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mux_reg_wr, ex_jump, ex_branch, ex_jalr;
  logic [1:0]  ex_ula_op, ex_alu_src1, ex_alu_src2;
  logic        ex_valid, load_use_stall;
  logic [31:0] stall_cnt, flush_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [31:0] CNT_ONE = 32'd1;
`else
  localparam logic [31:0] CNT_ONE = 32'd0;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in), .reg_wr_in(reg_wr_in),
    .mux_reg_wr_in(mux_reg_wr_in), .jump_in(jump_in), .branch_in(branch_in),
    .jalr_in(jalr_in), .ula_op_in(ula_op_in), .alu_src1_in(alu_src1_in),
    .alu_src2_in(alu_src2_in), .flush_in(flush_in), .hold_in(hold_in),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
    .ex_mux_reg_wr(ex_mux_reg_wr), .ex_jump(ex_jump), .ex_branch(ex_branch),
    .ex_jalr(ex_jalr), .ex_ula_op(ex_ula_op), .ex_alu_src1(ex_alu_src1),
    .ex_alu_src2(ex_alu_src2), .ex_valid(ex_valid), .load_use_stall(load_use_stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear the ID side to a bubble with no flush/hold.
  task automatic clr_id();
    id_valid = 1'b0; id_pc = 32'h0; id_rs1_val = 32'h0; id_rs2_val = 32'h0; id_imm = 32'h0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_funct = 4'h0;
    mem_rd_in = 1'b0; mem_wr_in = 1'b0; reg_wr_in = 1'b0; mux_reg_wr_in = 1'b0;
    jump_in = 1'b0; branch_in = 1'b0; jalr_in = 1'b0;
    ula_op_in = 2'b00; alu_src1_in = 2'b00; alu_src2_in = 2'b00;
    flush_in = 1'b0; hold_in = 1'b0;
  endtask

  task automatic r_type(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] v1, input logic [31:0] v2);
    clr_id();
    id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_val = v1; id_rs2_val = v2; reg_wr_in = 1'b1; ula_op_in = 2'b10;
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
    clr_id();
    id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_imm = 32'h4;
    mem_rd_in = 1'b1; reg_wr_in = 1'b1; mux_reg_wr_in = 1'b1; alu_src2_in = 2'b01;
  endtask

  task automatic sw(input logic [4:0] rs1, input logic [4:0] rs2);
    clr_id();
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; mem_wr_in = 1'b1; alu_src2_in = 2'b01;
  endtask

  initial begin
    clr_id();
    rst_n = 1'b0;
    #2;
    check_val("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check_val("reset_stall_cnt", stall_cnt, 32'd0);
    tick();
    rst_n = 1'b1;

    // Asynchronous reset mid-cycle
    r_type(5'd5, 5'd1, 5'd2, 32'h10, 32'h20);
    tick();
    check_val("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    check_val("async_rst_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    check_val("async_rst_ula_op", {30'd0, ex_ula_op}, 32'd0);
    check_val("async_rst_rs1_val", ex_rs1_val, 32'd0);
    tick();
    rst_n = 1'b1;

    // Normal R-type pass
    r_type(5'd5, 5'd1, 5'd2, 32'h10, 32'h20);
    id_pc = 32'h100; id_funct = 4'b1000;
    tick();
    check_val("rtype_reg_wr", {31'd0, ex_reg_wr}, 32'd1);
    check_val("rtype_ula_op", {30'd0, ex_ula_op}, 32'd2);
    check_val("rtype_rs1_val", ex_rs1_val, 32'h10);
    check_val("rtype_rs2_val", ex_rs2_val, 32'h20);
    check_val("rtype_rd", {27'd0, ex_rd}, 32'd5);
    check_val("rtype_pc", ex_pc, 32'h100);
    check_val("rtype_funct", {28'd0, ex_funct}, 32'd8);
    check_val("rtype_valid", {31'd0, ex_valid}, 32'd1);

    // Load-use: lw x7 then add x1,x7,x2
    lw(5'd7, 5'd2);
    check_val("lw_no_stall", {31'd0, load_use_stall}, 32'd0);
    tick();
    check_val("lw_mem_rd", {31'd0, ex_mem_rd}, 32'd1);
    r_type(5'd1, 5'd7, 5'd2, 32'h1, 32'h2);
    #1;
    check_val("lu_stall", {31'd0, load_use_stall}, 32'd1);
    tick();
    check_val("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_val("lu_bubble_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    check_val("lu_retry_no_stall", {31'd0, load_use_stall}, 32'd0);
    tick();
    check_val("lu_retry_valid", {31'd0, ex_valid}, 32'd1);
    check_val("lu_retry_rd", {27'd0, ex_rd}, 32'd1);
    check_val("lu_stall_cnt", stall_cnt, CNT_ONE);

    // No false hazard: lui x3 with id_rs1=7 against lw x7
    lw(5'd7, 5'd2);
    tick();
    clr_id();
    id_valid = 1'b1; id_rd = 5'd3; id_rs1 = 5'd7; id_rs2 = 5'd7;
    reg_wr_in = 1'b1; alu_src1_in = 2'b10; alu_src2_in = 2'b01;
    #1;
    check_val("lui_no_stall", {31'd0, load_use_stall}, 32'd0);

    // Store data depends on the load even with alu_src2 = imm; stall ignores hold
    sw(5'd1, 5'd7);
    hold_in = 1'b1;
    #1;
    check_val("sw_stall_hold", {31'd0, load_use_stall}, 32'd1);
    tick();
    check_val("hold_keep_rd", {27'd0, ex_rd}, 32'd7);
    check_val("hold_keep_mem_rd", {31'd0, ex_mem_rd}, 32'd1);
    check_val("hold_keep_valid", {31'd0, ex_valid}, 32'd1);
    check_val("hold_stall_cnt", stall_cnt, CNT_ONE);

    // Flush and hold together: flush wins
    flush_in = 1'b1;
    #1;
    check_val("flush_masks_stall", {31'd0, load_use_stall}, 32'd0);
    tick();
    check_val("flush_valid", {31'd0, ex_valid}, 32'd0);
    check_val("flush_mem_wr", {31'd0, ex_mem_wr}, 32'd0);
    check_val("flush_cnt", flush_cnt, CNT_ONE);
    check_val("flush_stall_cnt", stall_cnt, CNT_ONE);

    // Sanitisation: beq
    clr_id();
    id_valid = 1'b1; id_rd = 5'd4; id_rs1 = 5'd1; id_rs2 = 5'd2;
    reg_wr_in = 1'b1; branch_in = 1'b1; ula_op_in = 2'b01;
    tick();
    check_val("beq_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    check_val("beq_branch", {31'd0, ex_branch}, 32'd1);

    // addi x0
    clr_id();
    id_valid = 1'b1; id_rd = 5'd0; id_rs1 = 5'd1; reg_wr_in = 1'b1; alu_src2_in = 2'b01;
    tick();
    check_val("addi_x0_reg_wr", {31'd0, ex_reg_wr}, 32'd0);
    check_val("addi_x0_valid", {31'd0, ex_valid}, 32'd1);

    // mem_rd and mem_wr together: store wins
    sw(5'd1, 5'd2);
    mem_rd_in = 1'b1;
    tick();
    check_val("rdwr_mem_rd", {31'd0, ex_mem_rd}, 32'd0);
    check_val("rdwr_mem_wr", {31'd0, ex_mem_wr}, 32'd1);

    // Invalid ID: control cleared, data still captured
    clr_id();
    mem_rd_in = 1'b1; reg_wr_in = 1'b1; jump_in = 1'b1; id_pc = 32'h0000_0ABC;
    tick();
    check_val("inv_valid", {31'd0, ex_valid}, 32'd0);
    check_val("inv_ctrl", {29'd0, ex_mem_rd, ex_reg_wr, ex_jump}, 32'd0);
    check_val("inv_pc", ex_pc, 32'h0000_0ABC);

    // Load to x0 in EX never stalls
    lw(5'd0, 5'd2);
    tick();
    check_val("lwx0_mem_rd", {31'd0, ex_mem_rd}, 32'd1);
    r_type(5'd1, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    check_val("lwx0_no_stall", {31'd0, load_use_stall}, 32'd0);

    // Reset asserted mid-stall
    lw(5'd7, 5'd2);
    tick();
    r_type(5'd1, 5'd7, 5'd2, 32'h0, 32'h0);
    #1;
    check_val("pre_rst_stall", {31'd0, load_use_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_stall_drop", {31'd0, load_use_stall}, 32'd0);
    check_val("rst_stall_cnt", stall_cnt, 32'd0);
    check_val("rst_flush_cnt", flush_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
